// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory port arbiter.
//   ramstate_t  : status reported by the RAM model each cycle
//   grant_t     : which requester currently owns the RAM port
//   arb_state_t : arbiter FSM states
//   sat_inc32   : saturating increment used by the optional perf counters
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_D    = 2'd1,
    GNT_I0   = 2'd2,
    GNT_I1   = 2'd3
  } grant_t;

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational owner selection for mem_port_arbiter.
// Ports:
//   d_req      : data port wants the RAM (read or write)
//   i_req[1:0] : fetch request per core
//   rr_ptr     : core that gets first refusal among the fetch ports
//   starve_cnt : consecutive data grants taken while a fetch was waiting
//   pick       : chosen owner, GNT_NONE when nobody is requesting
module arb_pick
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       d_req,
  input  logic [1:0] i_req,
  input  logic       rr_ptr,
  input  logic [3:0] starve_cnt,
  output grant_t     pick
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic i_turn;
  logic i_sel;

  always_comb begin
    pick   = GNT_NONE;
    // Fetch wins when data is idle, or once data has used up its run.
    i_turn = (|i_req) && (!d_req || (starve_cnt == LIMIT));
    i_sel  = i_req[rr_ptr] ? rr_ptr : ~rr_ptr;
    if (i_turn) begin
      pick = i_sel ? GNT_I1 : GNT_I0;
    end else if (d_req) begin
      pick = GNT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between the bus controller data port (d) and the
// instruction-fetch ports of core 0 and core 1 (i0, i1). Data has priority,
// fetches alternate round-robin, and a starvation counter forces a fetch
// through after STARVE_LIMIT back-to-back data grants.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   d_ren/d_wen/d_addr/d_store, d_wait/d_load : data requester
//   i_ren/i_addr, i_wait/i_load               : fetch requesters (per core)
//   ram_ren/ram_wen/ram_addr/ram_store, ram_load/ram_state : RAM side
// Build option: define ARB_PERF_EN to add perf_d_cnt, perf_i0_cnt,
// perf_i1_cnt (completed grants) and perf_stall_cnt (cycles with a waiting
// requester); all saturate and clear on RST.
module mem_port_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   d_ren,
  input  logic                   d_wen,
  input  logic [ADDR_W-1:0]      d_addr,
  input  logic [WORD_W-1:0]      d_store,
  output logic                   d_wait,
  output logic [WORD_W-1:0]      d_load,
  input  logic [1:0]             i_ren,
  input  logic [1:0][ADDR_W-1:0] i_addr,
  output logic [1:0]             i_wait,
  output logic [WORD_W-1:0]      i_load,
  output logic                   ram_ren,
  output logic                   ram_wen,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [WORD_W-1:0]      ram_store,
  input  logic [WORD_W-1:0]      ram_load,
  input  ramstate_t              ram_state
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]            perf_d_cnt,
  output logic [31:0]            perf_i0_cnt,
  output logic [31:0]            perf_i1_cnt,
  output logic [31:0]            perf_stall_cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state, state_nxt;
  grant_t     owner, owner_nxt, pick;
  logic       rr_ptr, rr_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       d_req;
  logic       own_req;
  logic       done;

  assign d_req = d_ren | d_wen;

  arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .d_req     (d_req),
    .i_req     (i_ren),
    .rr_ptr    (rr_ptr),
    .starve_cnt(starve_cnt),
    .pick      (pick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ARB;
      owner      <= GNT_NONE;
      rr_ptr     <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rr_ptr     <= rr_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_nxt     = rr_ptr;
    starve_nxt = starve_cnt;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;
    ram_addr   = '0;
    ram_store  = '0;
    d_wait     = 1'b1;
    i_wait     = 2'b11;
    d_load     = '0;
    i_load     = '0;
    own_req    = 1'b0;
    done       = 1'b0;

    case (state)
      ARB: begin
        owner_nxt = pick;
        if (pick != GNT_NONE) state_nxt = GRANT;
      end

      GRANT: begin
        // Only the owner's inputs matter; a dropped request is an abort.
        case (owner)
          GNT_D:   own_req = d_req;
          GNT_I0:  own_req = i_ren[0];
          GNT_I1:  own_req = i_ren[1];
          default: own_req = 1'b0;
        endcase
        done = own_req && (ram_state == ACCESS);

        if (own_req) begin
          case (owner)
            GNT_D: begin
              ram_addr = d_addr;
              // Write wins when both enables are set; no read data returned.
              if (d_wen) begin
                ram_wen   = 1'b1;
                ram_store = d_store;
              end else begin
                ram_ren = 1'b1;
              end
              if (done) begin
                d_wait = 1'b0;
                if (!d_wen) d_load = ram_load;
              end
            end
            GNT_I0: begin
              ram_ren  = 1'b1;
              ram_addr = i_addr[0];
              if (done) begin
                i_wait[0] = 1'b0;
                i_load    = ram_load;
              end
            end
            GNT_I1: begin
              ram_ren  = 1'b1;
              ram_addr = i_addr[1];
              if (done) begin
                i_wait[1] = 1'b0;
                i_load    = ram_load;
              end
            end
            default: ;
          endcase
        end

        if (done) begin
          if (owner == GNT_D) begin
            if (|i_ren) starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
            else        starve_nxt = 4'd0;
          end else begin
            starve_nxt = 4'd0;
            rr_nxt     = (owner == GNT_I0);
          end
        end

        if (!own_req || done) begin
          state_nxt = ARB;
          owner_nxt = GNT_NONE;
        end
      end

      default: begin
        state_nxt = ARB;
        owner_nxt = GNT_NONE;
      end
    endcase
  end

`ifdef ARB_PERF_EN
  logic stall;

  assign stall = (d_req & d_wait) | (|(i_ren & i_wait));

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_d_cnt     <= '0;
      perf_i0_cnt    <= '0;
      perf_i1_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (done && owner == GNT_D)  perf_d_cnt  <= sat_inc32(perf_d_cnt);
      if (done && owner == GNT_I0) perf_i0_cnt <= sat_inc32(perf_i0_cnt);
      if (done && owner == GNT_I1) perf_i1_cnt <= sat_inc32(perf_i1_cnt);
      if (stall)                   perf_stall_cnt <= sat_inc32(perf_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             d_ren = 1'b0, d_wen = 1'b0;
  logic [31:0]      d_addr = '0, d_store = '0;
  logic             d_wait;
  logic [31:0]      d_load;
  logic [1:0]       i_ren = 2'b00;
  logic [1:0][31:0] i_addr = '0;
  logic [1:0]       i_wait;
  logic [31:0]      i_load;
  logic             ram_ren, ram_wen;
  logic [31:0]      ram_addr, ram_store;
  logic [31:0]      ram_load = '0;
  ramstate_t        ram_state = FREE;
`ifdef ARB_PERF_EN
  logic [31:0]      perf_d_cnt, perf_i0_cnt, perf_i1_cnt, perf_stall_cnt;
`endif

  mem_port_arbiter dut (
    .CLK(CLK), .RST(RST),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
    .d_wait(d_wait), .d_load(d_load),
    .i_ren(i_ren), .i_addr(i_addr), .i_wait(i_wait), .i_load(i_load),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_state(ram_state)
`ifdef ARB_PERF_EN
    , .perf_d_cnt(perf_d_cnt), .perf_i0_cnt(perf_i0_cnt),
    .perf_i1_cnt(perf_i1_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: owner -1 = nobody, 0 = data, 1 = core0, 2 = core1.
  int m_owner = -1, m_rr = 0, m_starve = 0;
  int m_pd = 0, m_pi0 = 0, m_pi1 = 0, m_pst = 0;
  bit m_alive, m_done;
  logic        e_d_wait, e_ren, e_wen;
  logic [1:0]  e_i_wait;
  logic [31:0] e_d_load, e_i_load, e_addr, e_store;

  string log_s;
  int    n_wen100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    n_total++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s: observed '%s' required '%s'", tag, obs, exp);
  endtask

  function automatic int model_pick();
    bit want_d, want_i;
    want_d = d_ren || d_wen;
    want_i = (i_ren != 2'b00);
    if (want_i && (!want_d || m_starve == LIMIT))
      return i_ren[m_rr] ? m_rr + 1 : 2 - m_rr;
    if (want_d) return 0;
    return -1;
  endfunction

  task automatic model_eval();
    e_d_wait = 1'b1; e_i_wait = 2'b11; e_d_load = '0; e_i_load = '0;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    m_alive = 1'b0; m_done = 1'b0;
    if (m_owner >= 0) begin
      m_alive = (m_owner == 0) ? (d_ren || d_wen) : i_ren[m_owner-1];
      if (m_alive) begin
        m_done = (ram_state == ACCESS);
        if (m_owner == 0) begin
          e_addr = d_addr;
          if (d_wen) begin e_wen = 1'b1; e_store = d_store; end
          else e_ren = 1'b1;
          if (m_done) begin
            e_d_wait = 1'b0;
            e_d_load = d_wen ? 32'd0 : ram_load;
          end
        end else begin
          e_ren  = 1'b1;
          e_addr = i_addr[m_owner-1];
          if (m_done) begin
            e_i_wait[m_owner-1] = 1'b0;
            e_i_load = ram_load;
          end
        end
      end
    end
  endtask

  task automatic model_step();
    bit stall;
    stall = ((d_ren || d_wen) && e_d_wait) || (i_ren[0] && e_i_wait[0]) || (i_ren[1] && e_i_wait[1]);
    if (RST) begin
      m_owner = -1; m_rr = 0; m_starve = 0;
      m_pd = 0; m_pi0 = 0; m_pi1 = 0; m_pst = 0;
    end else begin
      if (stall) m_pst++;
      if (m_owner < 0) m_owner = model_pick();
      else if (!m_alive) m_owner = -1;
      else if (m_done) begin
        if (m_owner == 0) begin
          m_pd++;
          m_starve = (i_ren != 2'b00) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        end else begin
          if (m_owner == 1) m_pi0++; else m_pi1++;
          m_starve = 0;
          m_rr = (m_owner == 1) ? 1 : 0;
        end
        m_owner = -1;
      end
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic tick();
    ram_load = $urandom();
    #1;
    model_eval();
    chk("d_wait", d_wait, e_d_wait);
    chk("i_wait", i_wait, e_i_wait);
    chk("ram_ren", ram_ren, e_ren);
    chk("ram_wen", ram_wen, e_wen);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_store", ram_store, e_store);
    chk("d_load", d_load, e_d_load);
    chk("i_load", i_load, e_i_load);
`ifdef ARB_PERF_EN
    chk("perf_d", perf_d_cnt, m_pd);
    chk("perf_i0", perf_i0_cnt, m_pi0);
    chk("perf_i1", perf_i1_cnt, m_pi1);
    chk("perf_stall", perf_stall_cnt, m_pst);
`endif
    if (d_wait === 1'b0)    log_s = {log_s, "D"};
    if (i_wait[0] === 1'b0) log_s = {log_s, "0"};
    if (i_wait[1] === 1'b0) log_s = {log_s, "1"};
    if (ram_wen === 1'b1 && ram_addr === 32'h100) n_wen100++;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    d_ren = 1'b0; d_wen = 1'b0; i_ren = 2'b00; ram_state = FREE;
  endtask

  task automatic rst_pulse();
    idle_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    log_s = "";
    n_wen100 = 0;
  endtask

  initial begin
    bit [2:0] r;
    log_s = "";
    n_wen100 = 0;

    // Reset held two cycles with every request asserted.
    d_ren = 1'b1; i_ren = 2'b11; ram_state = BUSY;
    @(posedge CLK);
    @(negedge CLK);
    tick();
    tick();
    RST = 1'b0;
    #1 chk("first_cycle_arb_ren", ram_ren, 1'b0);
    tick();
    #1 chk("first_grant_ren", ram_ren, 1'b1);
    chk("first_grant_addr", ram_addr, d_addr);

    // Data write: two BUSY cycles, then ACCESS.
    rst_pulse();
    d_wen = 1'b1; d_addr = 32'h100; d_store = 32'hDEADBEEF; ram_state = BUSY;
    tick();
    tick();
    tick();
    ram_state = ACCESS;
    #1 chk("wr_dwait_on_access", d_wait, 1'b0);
    chk("wr_store", ram_store, 32'hDEADBEEF);
    tick();
    d_wen = 1'b0; ram_state = FREE;
    tick();
    chk("wr_wen_cycles", n_wen100, 3);
    chk_str("wr_one_pulse", log_s, "D");

    // Round-robin between the fetch ports.
    rst_pulse();
    i_addr[0] = $urandom(); i_addr[1] = $urandom();
    i_ren = 2'b11; ram_state = ACCESS;
    repeat (8) tick();
    i_ren = 2'b00;
    tick();
    chk_str("rr_order", log_s, "0101");
`ifdef ARB_PERF_EN
    chk("rr_perf_i0", perf_i0_cnt, 2);
    chk("rr_perf_i1", perf_i1_cnt, 2);
`endif

    // Starvation: data plus core1 fetch held continuously.
    rst_pulse();
    d_ren = 1'b1; i_ren = 2'b10; ram_state = ACCESS;
    repeat (12) tick();
    idle_inputs();
    tick();
    chk_str("starve_order", log_s, "DDDD1D");

    // Abort: data drops its request while RAM is busy.
    rst_pulse();
    d_ren = 1'b1; d_addr = 32'h240; ram_state = BUSY;
    tick();
    tick();
    d_ren = 1'b0;
    #1 chk("abort_ren_low", ram_ren, 1'b0);
    chk("abort_no_pulse", d_wait, 1'b1);
    tick();
    d_ren = 1'b1;
    #1 chk("abort_back_in_arb", ram_ren, 1'b0);
    tick();
    #1 chk("abort_regrant", ram_ren, 1'b1);
    idle_inputs();
    tick();
    chk_str("abort_no_completion", log_s, "");

    // ERROR is not a completion.
    rst_pulse();
    i_addr[0] = 32'h0000_0A00;
    i_ren = 2'b01; ram_state = ERROR;
    repeat (4) tick();
    chk_str("err_no_completion", log_s, "");
    ram_state = ACCESS;
    #1 chk("err_access_wait", i_wait, 2'b10);
    tick();
    idle_inputs();
    tick();
    chk_str("err_one_pulse", log_s, "0");

    // Reset in the middle of a write.
    rst_pulse();
    d_wen = 1'b1; d_addr = 32'h300; ram_state = BUSY;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1 chk("rst_mid_wen", ram_wen, 1'b0);
    tick();
    idle_inputs();
    tick();

    // Randomized traffic against the model.
    rst_pulse();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) d_ren = ~d_ren;
      if ($urandom_range(0, 9) == 0) d_wen = ~d_wen;
      if ($urandom_range(0, 7) == 0) i_ren[0] = ~i_ren[0];
      if ($urandom_range(0, 7) == 0) i_ren[1] = ~i_ren[1];
      d_addr = $urandom(); d_store = $urandom();
      i_addr[0] = $urandom(); i_addr[1] = $urandom();
      r = 3'($urandom_range(0, 7));
      if (r < 3)       ram_state = BUSY;
      else if (r == 3) ram_state = FREE;
      else if (r == 4) ram_state = ERROR;
      else             ram_state = ACCESS;
      RST = ($urandom_range(0, 99) == 0);
      tick();
    end
    RST = 1'b0;
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
